cle_label_reader: RTL and testbench

- Readback side of the labelling datapath: scans the 1024x8 label SRAM (one label byte per pixel, 32x32 image) and re-packs it into 128 packed-binary bytes, in the same format as the input image ROM.
- Each output bit is 1 where the pixel belongs to a selected label.
- Counts matched pixels; feeds the checker and the export path through a valid/ready byte stream.

---
 rtl/cle_label_reader.sv | 167 ++++++++++++++++
 tb/tb_cle_label_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cle_label_reader.sv
// Label SRAM readback: scans 1024 label bytes and repacks selected-label matches
// into 128 packed mask bytes on a valid/ready stream. Define CLE_LBL_BBOX_EN for bounding-box outputs.
module cle_label_reader #(
  parameter int ADDR_W = 10,
  parameter int OUT_AW = 7,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        sel_label,
  input  logic [7:0]        sram_q,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_AW-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic [CNT_W-1:0]  pix_count,
  output logic              busy,
  output logic              done
`ifdef CLE_LBL_BBOX_EN
  ,
  output logic [4:0]        bbox_rmin,
  output logic [4:0]        bbox_rmax,
  output logic [4:0]        bbox_cmin,
  output logic [4:0]        bbox_cmax,
  output logic              bbox_valid
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          k_q;
  logic [OUT_AW-1:0]   byte_idx_q;
  logic [2:0]          lbl_q;
  logic [6:0]          shift_q;
  logic [ADDR_W-1:0]   sram_a_q;
  logic                out_valid_q;
  logic [OUT_AW-1:0]   out_addr_q;
  logic [7:0]          out_data_q;
  logic [CNT_W-1:0]    pix_q;
  logic                done_q;

  logic accept, capture, last_cap, xfer, finish, match;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_READ;
      S_READ: if (k_q == 4'd8) state_d = S_EMIT;
      S_EMIT: if (out_ready) state_d = (byte_idx_q == '1) ? S_DONE : S_READ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control strobes; sram_q lags the address by one cycle, so cycles 1..8 capture
  always_comb begin
    accept   = (state_q == S_IDLE) && start;
    capture  = (state_q == S_READ) && (k_q != 4'd0);
    last_cap = (state_q == S_READ) && (k_q == 4'd8);
    xfer     = (state_q == S_EMIT) && out_ready;
    finish   = xfer && (byte_idx_q == '1);
    busy     = (state_q == S_READ) || (state_q == S_EMIT);
    match    = (lbl_q != 3'd0) ? (sram_q == {5'b0, lbl_q}) : (sram_q != 8'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q         <= '0;
      byte_idx_q  <= '0;
      lbl_q       <= '0;
      shift_q     <= '0;
      sram_a_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      pix_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      if (accept) begin
        lbl_q      <= sel_label;
        pix_q      <= '0;
        byte_idx_q <= '0;
        k_q        <= '0;
        sram_a_q   <= '0;
        done_q     <= 1'b0;
      end
      if (state_q == S_READ) begin
        k_q <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
        if (k_q < 4'd7) sram_a_q <= sram_a_q + ADDR_W'(1);
      end
      if (capture) begin
        shift_q <= {shift_q[5:0], match};
        pix_q   <= pix_q + CNT_W'(match);
      end
      if (last_cap) begin
        out_data_q  <= {shift_q, match};
        out_addr_q  <= byte_idx_q;
        out_valid_q <= 1'b1;
      end
      if (xfer) begin
        out_valid_q <= 1'b0;
        if (!finish) begin
          byte_idx_q <= byte_idx_q + OUT_AW'(1);
          sram_a_q   <= {byte_idx_q + OUT_AW'(1), 3'b000};
        end
      end
      if (finish) done_q <= 1'b1;
    end
  end

`ifdef CLE_LBL_BBOX_EN
  logic [4:0] rmin_q, rmax_q, cmin_q, cmax_q;
  logic       bvalid_q;
  logic [ADDR_W-1:0] cap_pix;

  // Address of the pixel whose data is on sram_q this cycle
  assign cap_pix = {byte_idx_q, 3'(k_q - 4'd1)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rmin_q   <= 5'd31;
      rmax_q   <= '0;
      cmin_q   <= 5'd31;
      cmax_q   <= '0;
      bvalid_q <= 1'b0;
    end else if (accept) begin
      rmin_q   <= 5'd31;
      rmax_q   <= '0;
      cmin_q   <= 5'd31;
      cmax_q   <= '0;
      bvalid_q <= 1'b0;
    end else if (capture && match) begin
      if (cap_pix[9:5] < rmin_q) rmin_q <= cap_pix[9:5];
      if (cap_pix[9:5] > rmax_q) rmax_q <= cap_pix[9:5];
      if (cap_pix[4:0] < cmin_q) cmin_q <= cap_pix[4:0];
      if (cap_pix[4:0] > cmax_q) cmax_q <= cap_pix[4:0];
      bvalid_q <= 1'b1;
    end
  end

  assign bbox_rmin  = rmin_q;
  assign bbox_rmax  = rmax_q;
  assign bbox_cmin  = cmin_q;
  assign bbox_cmax  = cmax_q;
  assign bbox_valid = bvalid_q;
`endif

  assign sram_a    = sram_a_q;
  assign sram_wen  = 1'b1;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign pix_count = pix_q;
  assign done      = done_q;

endmodule

// File: tb/tb_cle_label_reader.sv
// Scoreboard bench for cle_label_reader: reference mask bytes are queued per scan
// and a negedge monitor pops them on every accepted output byte.
module tb_cle_label_reader;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [2:0]  sel_label;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        sram_wen, out_valid, busy, done;
  logic [6:0]  out_addr;
  logic [7:0]  out_data;
  logic [10:0] pix_count;
`ifdef CLE_LBL_BBOX_EN
  logic [4:0]  bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax;
  logic        bbox_valid;
`endif

  always #5 clk = ~clk;

  cle_label_reader #(.ADDR_W(10), .OUT_AW(7), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .sel_label(sel_label),
    .sram_q(sram_q), .sram_a(sram_a), .sram_wen(sram_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .pix_count(pix_count), .busy(busy), .done(done)
`ifdef CLE_LBL_BBOX_EN
    , .bbox_rmin(bbox_rmin), .bbox_rmax(bbox_rmax), .bbox_cmin(bbox_cmin),
    .bbox_cmax(bbox_cmax), .bbox_valid(bbox_valid)
`endif
  );

  logic [7:0] mem [1024];
  always @(posedge clk) sram_q <= mem[sram_a];

  int checks = 0;
  int errors = 0;
  logic [14:0] expq[$];
  int exp_cnt;
  int exp_rmin, exp_rmax, exp_cmin, exp_cmax, exp_bv;
  int popped = 0;
  bit ready_rand = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: mask bytes, count and bounding box straight from the pixel rules
  task automatic build_expect(input logic [2:0] lbl);
    expq.delete();
    exp_cnt = 0; exp_rmin = 31; exp_rmax = 0; exp_cmin = 31; exp_cmax = 0; exp_bv = 0;
    for (int b = 0; b < 128; b++) begin
      logic [7:0] byt;
      byt = 8'h00;
      for (int i = 0; i < 8; i++) begin
        int p;
        bit m;
        p = b * 8 + i;
        m = (lbl == 0) ? (mem[p] != 0) : (int'(mem[p]) == int'(lbl));
        if (m) begin
          byt = byt | (8'h80 >> i);
          exp_cnt++;
          exp_bv = 1;
          if (p / 32 < exp_rmin) exp_rmin = p / 32;
          if (p / 32 > exp_rmax) exp_rmax = p / 32;
          if (p % 32 < exp_cmin) exp_cmin = p % 32;
          if (p % 32 > exp_cmax) exp_cmax = p % 32;
        end
      end
      expq.push_back({7'(b), byt});
    end
  endtask

  // Ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: stall stability and scoreboard pops
  initial begin
    logic pv, pr;
    logic [24:0] phold;
    pv = 1'b0; pr = 1'b0; phold = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_hold", {out_addr, out_data, sram_a}, phold);
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", {out_addr, out_data});
          end else begin
            chk("byte", {out_addr, out_data}, expq.pop_front());
          end
          popped++;
        end
        pv = out_valid; pr = out_ready; phold = {out_addr, out_data, sram_a};
      end
    end
  end

  task automatic check_final();
    chk("pix_count", pix_count, exp_cnt);
    chk("bytes_left", expq.size(), 0);
    chk("busy_at_done", busy, 0);
    chk("sram_wen", sram_wen, 1);
`ifdef CLE_LBL_BBOX_EN
    chk("bbox_valid", bbox_valid, exp_bv);
    chk("bbox", {bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax},
        {5'(exp_rmin), 5'(exp_rmax), 5'(exp_cmin), 5'(exp_cmax)});
`endif
  endtask

  task automatic run_scan(input logic [2:0] lbl, input bit perturb, input bit check_time);
    int n;
    build_expect(lbl);
    popped = 0;
    @(posedge clk); #1;
    start = 1'b1; sel_label = lbl;
    @(posedge clk); #1;
    start = 1'b0; sel_label = 3'($urandom);
    n = 0;
    while (!done && n < 6000) begin
      @(posedge clk); #1;
      n++;
      if (perturb && n == 300) start = 1'b1;
      if (perturb && n == 301) start = 1'b0;
      if (perturb && n % 97 == 0) sel_label = 3'($urandom);
    end
    chk("done_within_budget", int'(n < 6000), 1);
    if (check_time) chk("scan_cycles", n, 1280);
    check_final();
  endtask

  task automatic check_reset_vals();
    chk("rst_sram_a", sram_a, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", sram_wen, 1);
`ifdef CLE_LBL_BBOX_EN
    chk("rst_bbox", {bbox_rmin, bbox_rmax, bbox_cmin, bbox_cmax, bbox_valid}, {5'd31, 5'd0, 5'd31, 5'd0, 1'b0});
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; sel_label = 3'd0;
    for (int p = 0; p < 1024; p++) mem[p] = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    reset = 1'b0;

    // All-zero image, then a start landing in the DONE cycle must be ignored
    run_scan(3'd0, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_in_done_busy", busy, 0);
    chk("start_in_done_done", done, 1);

    // Corner pixels
    mem[0] = 8'd1; mem[7] = 8'd1; mem[1023] = 8'd1;
    run_scan(3'd1, 1'b0, 1'b1);
    chk("corner_count", pix_count, 3);

    // p[2:0] ramp, single label then foreground
    for (int p = 0; p < 1024; p++) mem[p] = 8'(p % 8);
    run_scan(3'd3, 1'b0, 1'b1);
    run_scan(3'd0, 1'b0, 1'b1);

    // Random labels with backpressure and mid-scan perturbation
    ready_rand = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 1024; p++)
        mem[p] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      run_scan(3'($urandom), 1'b1, 1'b0);
    end

    // Reset during byte 40, then a clean scan
    build_expect(3'd2);
    popped = 0;
    @(posedge clk); #1 start = 1'b1; sel_label = 3'd2;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (popped < 40 && n < 6000) begin
      @(posedge clk); n++;
    end
    chk("reach_byte40", int'(n < 6000), 1);
    @(posedge clk); #3 reset = 1'b1;
    #1 check_reset_vals();
    expq.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    run_scan(3'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
